// File: rtl/enet_rx_addr_filter.sv
// Receive destination-address filter: perfect-match slots, CRC-32 hash tables and
// promiscuous/broadcast control, one registered accept/reject decision per frame.
module enet_rx_addr_filter #(
  parameter int NUM_PADDR = 4,
  parameter int SLOT_W    = 2,
  parameter int ADDR_W    = 5
) (
  input  logic              rx_clk,
  input  logic              rst,
  input  logic              reg_wen,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_sof,
  input  logic              rx_eof,
  output logic              match_valid,
  output logic              match_accept,
  output logic [2:0]        match_kind,
  output logic [SLOT_W-1:0] match_slot
);

  localparam int IHASH_IDX = 2 * NUM_PADDR;
  localparam int GHASH_IDX = IHASH_IDX + 2;
  localparam int CTRL_IDX  = IHASH_IDX + 4;

  typedef enum logic [1:0] {IDLE, ADDR, WAIT_EOF} state_t;

  logic [31:0] slot_lo_reg [NUM_PADDR];
  logic [15:0] slot_hi_reg [NUM_PADDR];
  logic        slot_en_reg [NUM_PADDR];
  logic [63:0] ihash_reg, ghash_reg;
  logic        promisc_reg, bcast_rej_reg;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [31:0] crc_reg, crc_next;
  logic [39:0] da_reg, da_next;
  logic              mv_reg, mv_next;
  logic              acc_reg, acc_next;
  logic [2:0]        kind_reg, kind_next;
  logic [SLOT_W-1:0] slot_reg, slot_next;

  logic [31:0]          crc_step, crc_first;
  logic [47:0]          da_full;
  logic [5:0]           hash_idx;
  logic [NUM_PADDR-1:0] slot_hit;
  logic                 hit_any;
  logic [SLOT_W-1:0]    hit_slot;
  logic                 dec_accept;
  logic [2:0]           dec_kind;
  logic [SLOT_W-1:0]    dec_slot;

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++)
      c = (c >> 1) ^ (32'hEDB88320 & {32{c[0] ^ d[i]}});
    return c;
  endfunction

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_PADDR; k++) begin
        slot_lo_reg[k] <= '0;
        slot_hi_reg[k] <= '0;
        slot_en_reg[k] <= 1'b0;
      end
      ihash_reg     <= '0;
      ghash_reg     <= '0;
      promisc_reg   <= 1'b0;
      bcast_rej_reg <= 1'b0;
    end else if (reg_wen) begin
      for (int k = 0; k < NUM_PADDR; k++) begin
        if (reg_addr == ADDR_W'(2 * k)) slot_lo_reg[k] <= reg_wdata;
        if (reg_addr == ADDR_W'(2 * k + 1)) begin
          slot_hi_reg[k] <= reg_wdata[31:16];
          slot_en_reg[k] <= reg_wdata[0];
        end
      end
      if (reg_addr == ADDR_W'(IHASH_IDX))     ihash_reg[31:0]  <= reg_wdata;
      if (reg_addr == ADDR_W'(IHASH_IDX + 1)) ihash_reg[63:32] <= reg_wdata;
      if (reg_addr == ADDR_W'(GHASH_IDX))     ghash_reg[31:0]  <= reg_wdata;
      if (reg_addr == ADDR_W'(GHASH_IDX + 1)) ghash_reg[63:32] <= reg_wdata;
      if (reg_addr == ADDR_W'(CTRL_IDX)) begin
        promisc_reg   <= reg_wdata[0];
        bcast_rej_reg <= reg_wdata[1];
      end
    end
  end

  always_comb begin
    reg_rdata = '0;
    for (int k = 0; k < NUM_PADDR; k++) begin
      if (reg_addr == ADDR_W'(2 * k))     reg_rdata = slot_lo_reg[k];
      if (reg_addr == ADDR_W'(2 * k + 1)) reg_rdata = {slot_hi_reg[k], 15'b0, slot_en_reg[k]};
    end
    if (reg_addr == ADDR_W'(IHASH_IDX))     reg_rdata = ihash_reg[31:0];
    if (reg_addr == ADDR_W'(IHASH_IDX + 1)) reg_rdata = ihash_reg[63:32];
    if (reg_addr == ADDR_W'(GHASH_IDX))     reg_rdata = ghash_reg[31:0];
    if (reg_addr == ADDR_W'(GHASH_IDX + 1)) reg_rdata = ghash_reg[63:32];
    if (reg_addr == ADDR_W'(CTRL_IDX))      reg_rdata = {30'b0, bcast_rej_reg, promisc_reg};
  end

  // Decision logic looks at the sixth byte live, so DA and CRC include rx_data.
  assign crc_step  = crc_byte(crc_reg, rx_data);
  assign crc_first = crc_byte(32'hFFFF_FFFF, rx_data);
  assign da_full   = {da_reg, rx_data};
  assign hash_idx  = crc_step[31:26];

  for (genvar gi = 0; gi < NUM_PADDR; gi++) begin : g_slot
    assign slot_hit[gi] = slot_en_reg[gi] && ({slot_lo_reg[gi], slot_hi_reg[gi]} == da_full);
  end

  // Scan downwards so the lowest matching slot is the one left standing.
  always_comb begin
    hit_any  = 1'b0;
    hit_slot = '0;
    for (int k = NUM_PADDR - 1; k >= 0; k--) begin
      if (slot_hit[k]) begin
        hit_any  = 1'b1;
        hit_slot = SLOT_W'(k);
      end
    end
  end

  always_comb begin
    dec_accept = 1'b0;
    dec_kind   = 3'd0;
    dec_slot   = '0;
    if (promisc_reg) begin
      dec_accept = 1'b1;
      dec_kind   = 3'd5;
    end else if (da_full == 48'hFFFF_FFFF_FFFF) begin
      dec_accept = !bcast_rej_reg;
      dec_kind   = bcast_rej_reg ? 3'd0 : 3'd2;
    end else if (hit_any) begin
      dec_accept = 1'b1;
      dec_kind   = 3'd1;
      dec_slot   = hit_slot;
    end else if (da_full[40] && ghash_reg[hash_idx]) begin
      dec_accept = 1'b1;
      dec_kind   = 3'd3;
    end else if (!da_full[40] && ihash_reg[hash_idx]) begin
      dec_accept = 1'b1;
      dec_kind   = 3'd4;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    crc_next   = crc_reg;
    da_next    = da_reg;
    mv_next    = 1'b0;
    acc_next   = 1'b0;
    kind_next  = 3'd0;
    slot_next  = '0;
    if (rx_valid) begin
      if (rx_sof) begin
        // A start byte always begins a fresh frame, abandoning any frame in progress.
        if (rx_eof) begin
          mv_next    = 1'b1;
          state_next = IDLE;
          cnt_next   = 3'd0;
        end else begin
          state_next = ADDR;
          cnt_next   = 3'd1;
          crc_next   = crc_first;
          da_next    = {32'b0, rx_data};
        end
      end else begin
        case (state_reg)
          ADDR: begin
            if (cnt_reg == 3'd5) begin
              mv_next    = 1'b1;
              acc_next   = dec_accept;
              kind_next  = dec_kind;
              slot_next  = dec_slot;
              state_next = rx_eof ? IDLE : WAIT_EOF;
              cnt_next   = 3'd0;
            end else if (rx_eof) begin
              mv_next    = 1'b1;
              state_next = IDLE;
              cnt_next   = 3'd0;
            end else begin
              cnt_next = cnt_reg + 3'd1;
              crc_next = crc_step;
              da_next  = {da_reg[31:0], rx_data};
            end
          end
          WAIT_EOF: if (rx_eof) state_next = IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
      crc_reg   <= '0;
      da_reg    <= '0;
      mv_reg    <= 1'b0;
      acc_reg   <= 1'b0;
      kind_reg  <= 3'd0;
      slot_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      crc_reg   <= crc_next;
      da_reg    <= da_next;
      mv_reg    <= mv_next;
      acc_reg   <= acc_next;
      kind_reg  <= kind_next;
      slot_reg  <= slot_next;
    end
  end

  assign match_valid  = mv_reg;
  assign match_accept = acc_reg;
  assign match_kind   = kind_reg;
  assign match_slot   = slot_reg;

endmodule

// File: tb/tb_enet_rx_addr_filter.sv
// Randomised scoreboard bench for enet_rx_addr_filter: frames and register writes are
// scored against a frame-level reference model; a monitor checks each decision pulse.
module tb_enet_rx_addr_filter;
  localparam int NP = 4;
  localparam int SW = 2;
  localparam int AW = 5;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

  logic          rx_clk = 1'b0;
  logic          rst = 1'b1;
  logic          reg_wen = 1'b0;
  logic [AW-1:0] reg_addr = '0;
  logic [31:0]   reg_wdata = '0;
  logic [31:0]   reg_rdata;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_sof = 1'b0;
  logic          rx_eof = 1'b0;
  logic          match_valid, match_accept;
  logic [2:0]    match_kind;
  logic [SW-1:0] match_slot;

  enet_rx_addr_filter #(.NUM_PADDR(NP), .SLOT_W(SW), .ADDR_W(AW)) dut (
    .rx_clk(rx_clk), .rst(rst), .reg_wen(reg_wen), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_sof(rx_sof), .rx_eof(rx_eof),
    .match_valid(match_valid), .match_accept(match_accept),
    .match_kind(match_kind), .match_slot(match_slot));

  always #5 rx_clk = ~rx_clk;

  int cyc = 0;
  always @(posedge rx_clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic          acc;
    logic [2:0]    kind;
    logic [SW-1:0] slot;
  } exp_t;
  exp_t expq[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference register state
  logic [31:0] m_lo [NP];
  logic [15:0] m_hi [NP];
  logic        m_en [NP];
  logic [63:0] m_ih, m_gh;
  logic [1:0]  m_ctrl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NP; k++) begin
      m_lo[k] = '0; m_hi[k] = '0; m_en[k] = 1'b0;
    end
    m_ih = '0; m_gh = '0; m_ctrl = '0;
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [31:0] d);
    int ai = int'(a);
    for (int k = 0; k < NP; k++) begin
      if (ai == 2 * k) m_lo[k] = d;
      if (ai == 2 * k + 1) begin m_hi[k] = d[31:16]; m_en[k] = d[0]; end
    end
    if (ai == 2 * NP)     m_ih[31:0]  = d;
    if (ai == 2 * NP + 1) m_ih[63:32] = d;
    if (ai == 2 * NP + 2) m_gh[31:0]  = d;
    if (ai == 2 * NP + 3) m_gh[63:32] = d;
    if (ai == 2 * NP + 4) m_ctrl = d[1:0];
  endfunction

  function automatic logic [31:0] model_rd(input logic [AW-1:0] a);
    int ai = int'(a);
    for (int k = 0; k < NP; k++) begin
      if (ai == 2 * k)     return m_lo[k];
      if (ai == 2 * k + 1) return {m_hi[k], 15'b0, m_en[k]};
    end
    if (ai == 2 * NP)     return m_ih[31:0];
    if (ai == 2 * NP + 1) return m_ih[63:32];
    if (ai == 2 * NP + 2) return m_gh[31:0];
    if (ai == 2 * NP + 3) return m_gh[63:32];
    if (ai == 2 * NP + 4) return {30'b0, m_ctrl};
    return 32'h0;
  endfunction

  // Hash index: reflected CRC-32 over all six DA bytes, LSB of each byte first
  function automatic int model_hash(input logic [47:0] da);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int b = 0; b < 6; b++) begin
      logic [7:0] by = da[47 - 8 * b -: 8];
      for (int i = 0; i < 8; i++)
        c = (c >> 1) ^ (32'hEDB88320 & {32{c[0] ^ by[i]}});
    end
    return int'(c[31:26]);
  endfunction

  function automatic exp_t decide(input logic [47:0] da);
    exp_t x = '{cyc: 0, acc: 1'b0, kind: 3'd0, slot: '0};
    int h = model_hash(da);
    if (m_ctrl[0]) begin
      x.acc = 1'b1; x.kind = 3'd5;
      return x;
    end
    if (da == BCAST) begin
      x.acc = !m_ctrl[1]; x.kind = m_ctrl[1] ? 3'd0 : 3'd2;
      return x;
    end
    for (int k = 0; k < NP; k++) begin
      if (m_en[k] && {m_lo[k], m_hi[k]} == da) begin
        x.acc = 1'b1; x.kind = 3'd1; x.slot = SW'(k);
        return x;
      end
    end
    if (da[40] && m_gh[h])       begin x.acc = 1'b1; x.kind = 3'd3; end
    else if (!da[40] && m_ih[h]) begin x.acc = 1'b1; x.kind = 3'd4; end
    return x;
  endfunction

  // Monitor: pops one expectation per decision pulse, flags missing or stray pulses
  exp_t mon_e;
  always @(negedge rx_clk) begin
    if (mon_en) begin
      if (expq.size() > 0 && expq[0].cyc < cyc) begin
        mon_e = expq.pop_front();
        chk("missing_pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
      if (match_valid === 1'b1) begin
        if (expq.size() == 0) begin
          chk("unexpected_pulse", 32'(match_valid), 32'h0);
        end else begin
          mon_e = expq.pop_front();
          chk("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("accept", 32'(match_accept), 32'(mon_e.acc));
          chk("kind", 32'(match_kind), 32'(mon_e.kind));
          chk("slot", 32'(match_slot), 32'(mon_e.slot));
        end
      end else begin
        chk("idle_outputs", {27'b0, match_valid, match_accept, match_kind}, 32'h0);
        chk("idle_slot", 32'(match_slot), 32'h0);
      end
    end
  end

  task automatic step(input bit wen, input logic [AW-1:0] a, input logic [31:0] wd,
                      input bit v, input logic [7:0] d, input bit s, input bit e, input bit r);
    reg_wen = wen; reg_addr = a; reg_wdata = wd;
    rx_valid = v; rx_data = d; rx_sof = s; rx_eof = e; rst = r;
    @(posedge rx_clk);
    #1;
    if (r) model_reset();
    else if (wen) model_write(a, wd);
    reg_wen = 1'b0; rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rst = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    step(1'b1, AW'(a), d, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return AW'($urandom_range(0, 15));
  endfunction

  function automatic logic [31:0] rnd_data(input logic [AW-1:0] a);
    if (int'(a) == 2 * NP + 4) return {30'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0)};
    if (int'(a) >= 2 * NP) return $urandom & $urandom;
    return $urandom;
  endfunction

  task automatic idle_step(input bit rnd_wr);
    logic [AW-1:0] a = rnd_addr();
    bit w = rnd_wr && ($urandom_range(0, 3) == 0);
    step(w, a, rnd_data(a), 1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic send_frame(input logic [47:0] da, input int len, input bit do_eof,
                            input bit gaps, input bit rnd_wr,
                            input bit wr6, input int wa, input logic [31:0] wd);
    for (int i = 0; i < len; i++) begin
      logic [7:0]    b;
      bit            e, w;
      logic [AW-1:0] a;
      logic [31:0]   d;
      exp_t          x;
      if (gaps && $urandom_range(0, 3) == 0) idle_step(rnd_wr);
      b = (i < 6) ? da[47 - 8 * i -: 8] : 8'($urandom);
      e = do_eof && (i == len - 1);
      if (i == 5) begin
        x = decide(da); x.cyc = cyc + 1; expq.push_back(x);
      end else if (e && i < 5) begin
        x = '{cyc: cyc + 1, acc: 1'b0, kind: 3'd0, slot: '0}; expq.push_back(x);
      end
      w = 1'b0; a = '0; d = '0;
      if (wr6 && i == 5) begin
        w = 1'b1; a = AW'(wa); d = wd;
      end else if (rnd_wr && $urandom_range(0, 7) == 0) begin
        a = rnd_addr(); w = 1'b1; d = rnd_data(a);
      end
      step(w, a, d, 1'b1, b, i == 0, e, 1'b0);
    end
  endtask

  task automatic frame(input logic [47:0] da, input int len);
    send_frame(da, len, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0);
  endtask

  task automatic rd_all();
    for (int a = 0; a < 32; a++) begin
      reg_addr = AW'(a);
      #1;
      chk("rdata", reg_rdata, model_rd(AW'(a)));
    end
    reg_addr = '0;
  endtask

  initial begin
    logic [47:0] da;
    int h, len;
    model_reset();
    repeat (3) step(1'b0, '0, '0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    rd_all();

    frame(BCAST, 6);
    wr(2 * NP + 4, 32'h2);
    frame(BCAST, 7);
    wr(2 * NP + 4, 32'h0);

    wr(2, 32'h0011_2233); wr(3, 32'h4455_0001);
    frame(48'h0011_2233_4455, 8);
    wr(3, 32'h4455_0000);
    frame(48'h0011_2233_4455, 6);
    wr(3, 32'h4455_0001); wr(6, 32'h0011_2233); wr(7, 32'h4455_0001);
    frame(48'h0011_2233_4455, 6);

    wr(2 * NP + 2, 32'hFFFF_FFFF); wr(2 * NP + 3, 32'hFFFF_FFFF);
    frame(48'h0100_5E00_0001, 6);
    wr(2 * NP + 2, 32'h0); wr(2 * NP + 3, 32'h0);
    frame(48'h0100_5E00_0001, 6);
    h = model_hash(48'h0100_5E00_0001);
    if (h < 32) wr(2 * NP + 2, 32'h1 << h);
    else        wr(2 * NP + 3, 32'h1 << (h - 32));
    frame(48'h0100_5E00_0001, 6);

    wr(2 * NP + 4, 32'h3);
    frame(48'h0200_0000_0009, 6);
    wr(2 * NP + 4, 32'h0);

    frame(48'h0011_2233_4455, 3);
    frame(48'h0011_2233_4455, 1);
    send_frame(48'h0011_2233_4455, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    frame(48'h0011_2233_4455, 9);

    wr(0, 32'h0A0B_0C0D); wr(1, 32'h0E0F_0001);
    send_frame(48'h0A0B_0C0D_0E0F, 6, 1'b1, 1'b0, 1'b0, 1'b1, 0, 32'h1234_5678);
    frame(48'h0A0B_0C0D_0E0F, 6);

    send_frame(BCAST, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    step(1'b0, '0, '0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
    rd_all();

    frame(BCAST, 6);
    frame(48'h0600_0000_0001, 6);

    for (int k = 0; k < NP; k++) begin
      wr(2 * k, $urandom); wr(2 * k + 1, $urandom);
    end
    for (int a = 2 * NP; a < 2 * NP + 4; a++) wr(a, $urandom & $urandom);
    for (int n = 0; n < 250; n++) begin
      int k = $urandom_range(0, NP - 1);
      case ($urandom_range(0, 3))
        0: da = {$urandom, 16'($urandom)};
        1: da = BCAST;
        2: da = {m_lo[k], m_hi[k]};
        default: da = {8'($urandom) | 8'h01, $urandom, 8'($urandom)};
      endcase
      len = $urandom_range(1, 12);
      send_frame(da, len, $urandom_range(0, 5) != 0, 1'b1, 1'b1, 1'b0, 0, 32'h0);
    end
    repeat (10) idle_step(1'b0);
    chk("queue_empty", 32'(expq.size()), 32'h0);
    rd_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
